// File: rtl/cr16_control_fsm.sv
// cr16_control_fsm
//   Multicycle Moore control unit for the 16-bit CR16-subset datapath.
//   Sequences fetch / decode / execute / memory / writeback and drives every
//   datapath control input, plus the memory write strobe.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-low reset
//   instr           latched instruction from the datapath
//   psr             flag register: C=0, L=2, F=5, Z=6, N=7
//   PCEN .. jalEN   1-bit datapath controls
//   shiftAmt        shift amount field (instr[3:0])
//   shifterControl  shifter operation (ext field)
//   ALUcond         ALU operation (ext for R-type, op for immediates)
//   chooseResult    result mux: 00 shift, 01 ALU, 10 pcALU, 11 Rlink
//   memWrite        one-cycle memory write strobe
module cr16_control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instr,
    input  logic [7:0]         psr,
    output logic               PCEN,
    output logic               PSREN,
    output logic               nextInstruction,
    output logic               updateAddress,
    output logic               StoreReg,
    output logic               WriteData,
    output logic               regWrite,
    output logic               ZeroExtend,
    output logic               PCinstruction,
    output logic               SrcB,
    output logic               resultEn,
    output logic               immediateRegEN,
    output logic               jumpEN,
    output logic               BranchEN,
    output logic               jalEN,
    output logic [REGBITS-1:0] shiftAmt,
    output logic [REGBITS-1:0] shifterControl,
    output logic [REGBITS-1:0] ALUcond,
    output logic [1:0]         chooseResult,
    output logic               memWrite
);

    typedef enum logic [3:0] {
        FETCH,
        FWAIT,
        DECODE,
        ALU_EX,
        SH_EX,
        WB,
        PCUP,
        LD_ADDR,
        LD_WAIT,
        LD_WB,
        ST,
        BR,
        JC,
        JAL_EX,
        JAL_WB
    } state_t;

    state_t state, nextState;

    logic [3:0] op, ext, condCode, aluCode;
    logic       isRtype, isImmAlu, isZext, setsFlags, isCmp, taken;
    logic       unusedPsr;

    assign op       = instr[15:12];
    assign condCode = instr[11:8];
    assign ext      = instr[7:4];

    // Flags not referenced by any condition code.
    assign unusedPsr = ^{psr[4:3], psr[1]};

    always_comb begin
        isRtype  = (op == 4'b0000);
        isImmAlu = 1'b0;
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b1001, 4'b1011, 4'b1101: isImmAlu = 1'b1;
            default:                   isImmAlu = 1'b0;
        endcase
        isZext    = (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011);
        aluCode   = isRtype ? ext : op;
        setsFlags = (aluCode == 4'b0101) || (aluCode == 4'b1001) || (aluCode == 4'b1011);
        isCmp     = (aluCode == 4'b1011);
    end

    // Branch/jump condition evaluation; unlisted codes are never taken.
    always_comb begin
        case (condCode)
            4'b0000: taken = psr[6];
            4'b0001: taken = ~psr[6];
            4'b0010: taken = psr[0];
            4'b0011: taken = ~psr[0];
            4'b0110: taken = psr[7];
            4'b0111: taken = ~psr[7];
            4'b1000: taken = psr[5];
            4'b1001: taken = ~psr[5];
            4'b1010: taken = psr[2];
            4'b1011: taken = ~psr[2];
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= nextState;
    end

    always_comb begin
        nextState       = FETCH;
        PCEN            = 1'b0;
        PSREN           = 1'b0;
        nextInstruction = 1'b0;
        updateAddress   = 1'b1;
        StoreReg        = 1'b0;
        WriteData       = 1'b0;
        regWrite        = 1'b0;
        ZeroExtend      = 1'b0;
        PCinstruction   = 1'b0;
        SrcB            = 1'b0;
        resultEn        = 1'b0;
        immediateRegEN  = 1'b0;
        jumpEN          = 1'b0;
        BranchEN        = 1'b0;
        jalEN           = 1'b0;
        shiftAmt        = '0;
        shifterControl  = '0;
        ALUcond         = '0;
        chooseResult    = 2'b00;
        memWrite        = 1'b0;

        case (state)
            FETCH: nextState = FWAIT;
            FWAIT: begin
                nextInstruction = 1'b1;
                nextState       = DECODE;
            end
            DECODE: begin
                immediateRegEN = 1'b1;
                ZeroExtend     = isZext;
                if (isRtype || isImmAlu) nextState = ALU_EX;
                else if (op == 4'b0100) begin
                    case (ext)
                        4'b0000: nextState = LD_ADDR;
                        4'b0100: nextState = ST;
                        4'b1000: nextState = JAL_EX;
                        4'b1100: nextState = JC;
                        default: nextState = PCUP;
                    endcase
                end
                else if (op == 4'b1000) nextState = SH_EX;
                else if (op == 4'b1100) nextState = BR;
                else                    nextState = PCUP;
            end
            ALU_EX: begin
                resultEn     = 1'b1;
                chooseResult = 2'b01;
                SrcB         = isRtype;
                PSREN        = setsFlags;
                ALUcond      = REGBITS'(aluCode);
                nextState    = isCmp ? PCUP : WB;
            end
            SH_EX: begin
                resultEn       = 1'b1;
                chooseResult   = 2'b00;
                SrcB           = (ext == 4'b0100);
                shifterControl = REGBITS'(ext);
                shiftAmt       = REGBITS'(instr[3:0]);
                nextState      = WB;
            end
            WB: begin
                regWrite  = 1'b1;
                WriteData = 1'b1;
                nextState = PCUP;
            end
            PCUP: begin
                PCinstruction = 1'b1;
                PCEN          = 1'b1;
                nextState     = FETCH;
            end
            LD_ADDR: begin
                updateAddress = 1'b0;
                nextState     = LD_WAIT;
            end
            LD_WAIT: begin
                updateAddress = 1'b0;
                nextState     = LD_WB;
            end
            LD_WB: begin
                regWrite  = 1'b1;
                nextState = PCUP;
            end
            ST: begin
                updateAddress = 1'b0;
                StoreReg      = 1'b1;
                memWrite      = 1'b1;
                nextState     = PCUP;
            end
            BR: begin
                PCinstruction = 1'b1;
                PCEN          = 1'b1;
                BranchEN      = taken;
                nextState     = FETCH;
            end
            JC: begin
                SrcB          = 1'b1;
                PCEN          = 1'b1;
                jumpEN        = taken;
                PCinstruction = ~taken;
                nextState     = FETCH;
            end
            JAL_EX: begin
                SrcB         = 1'b1;
                jalEN        = 1'b1;
                chooseResult = 2'b11;
                resultEn     = 1'b1;
                PCEN         = 1'b1;
                nextState    = JAL_WB;
            end
            JAL_WB: begin
                regWrite  = 1'b1;
                WriteData = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase

        // Reset suppresses every state-changing strobe so an interrupted
        // instruction cannot leave a partial write behind.
        if (!reset) begin
            PCEN            = 1'b0;
            PSREN           = 1'b0;
            nextInstruction = 1'b0;
            regWrite        = 1'b0;
            memWrite        = 1'b0;
            resultEn        = 1'b0;
            immediateRegEN  = 1'b0;
        end
    end

endmodule
